// File: rtl/pal_ram_ctrl_pkg.sv
// Shared types and constants for the palette RAM controller.
package pal_ctrl_pkg;
   localparam int PAL_ADDR_W = 14;
   localparam int PAL_DATA_W = 32;

   typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, DONE} pal_state_e;
   typedef enum logic {REQ_CPU, REQ_SS} pal_req_e;
endpackage

// File: rtl/pal_ram_ctrl_if.sv
// CPU and savestate request buses into the palette RAM controller.
interface pal_ram_ctrl_if
   import pal_ctrl_pkg::*;
#(
   parameter int ADDR_W = PAL_ADDR_W,
   parameter int DATA_W = PAL_DATA_W
);
   // Handshake: req (with we/hw/addr/wdata) is held high until ack; ack is a
   // one-cycle pulse with rdata valid alongside it; req drops on the edge that samples ack.
   logic              cpu_req;
   logic              cpu_we;
   logic              cpu_hw;
   logic [ADDR_W:0]   cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   logic              ss_req;
   logic              ss_we;
   logic [ADDR_W-1:0] ss_addr;
   logic [DATA_W-1:0] ss_wdata;
   logic              ss_ack;
   logic [DATA_W-1:0] ss_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_hw, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata,
      output ss_req, ss_we, ss_addr, ss_wdata,
      input  ss_ack, ss_rdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_hw, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata,
      input  ss_req, ss_we, ss_addr, ss_wdata,
      output ss_ack, ss_rdata
   );
endinterface

// File: rtl/pal_ram_ctrl_arb.sv
// Two-input round-robin arbiter; on a tie the requester not served last wins.
module pal_rr_arbiter
   import pal_ctrl_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  logic     i_cpu_req,
   input  logic     i_ss_req,
   input  logic     i_accept,
   output logic     o_grant_valid,
   output pal_req_e o_grant_id
);
   pal_req_e r_last_grant;

   always_comb begin
      o_grant_valid = i_cpu_req | i_ss_req;
      o_grant_id    = REQ_CPU;
      if (i_cpu_req && i_ss_req) begin
         o_grant_id = (r_last_grant == REQ_SS) ? REQ_CPU : REQ_SS;
      end else if (i_ss_req) begin
         o_grant_id = REQ_SS;
      end
   end

   // Starting at SS makes the first tie after reset go to the CPU.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_last_grant <= REQ_SS;
      end else if (i_accept && o_grant_valid) begin
         r_last_grant <= o_grant_id;
      end
   end
endmodule

// File: rtl/pal_ram_ctrl.sv
// Palette RAM port-A sequencer (CPU + savestate, halfword read-modify-write)
// and registered renderer read on port B.
module pal_ram_ctrl
   import pal_ctrl_pkg::*;
#(
   parameter int ADDR_W = PAL_ADDR_W,
   parameter int DATA_W = PAL_DATA_W
)(
   input  logic              clock,
   input  logic              reset,
   pal_ram_ctrl_if.slave     bus,
   output logic              ram_wren_a,
   output logic [ADDR_W-1:0] ram_address_a,
   output logic [DATA_W-1:0] ram_data_a,
   input  logic [DATA_W-1:0] ram_q_a,
   input  logic [DATA_W-1:0] ram_q_b,
   input  logic [ADDR_W-1:0] render_addr,
   output logic [DATA_W-1:0] render_data,
   output logic [ADDR_W-1:0] ram_address_b,
   output logic              ram_wren_b,
   output pal_state_e        dbg_state
);
   localparam int HALF_W = DATA_W / 2;

   pal_state_e        r_state;
   pal_state_e        w_next;
   pal_req_e          r_id;
   logic              r_we;
   logic              r_hw;
   logic              r_half;
   logic [ADDR_W-1:0] r_word;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_merge;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_ss_rdata;
   logic [DATA_W-1:0] r_render_data;

   logic              w_grant_valid;
   pal_req_e          w_grant_id;
   logic              w_accept;
   logic              w_wren;
   logic [DATA_W-1:0] w_data;
   logic              w_cpu_ack;
   logic              w_ss_ack;
   logic [DATA_W-1:0] w_merged;

   pal_rr_arbiter u_arb (
      .clock         (clock),
      .reset         (reset),
      .i_cpu_req     (bus.cpu_req),
      .i_ss_req      (bus.ss_req),
      .i_accept      (w_accept),
      .o_grant_valid (w_grant_valid),
      .o_grant_id    (w_grant_id)
   );

   assign w_merged = r_half ? {r_wdata[HALF_W-1:0], r_merge[HALF_W-1:0]}
                            : {r_merge[DATA_W-1:HALF_W], r_wdata[HALF_W-1:0]};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_wren    = 1'b0;
      w_data    = '0;
      w_cpu_ack = 1'b0;
      w_ss_ack  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grant_valid) begin
               w_accept = 1'b1;
               w_next   = ACCESS;
            end
         end
         ACCESS: begin
            if (r_we && r_hw) begin
               w_next = MERGE_WR;
            end else begin
               w_wren = r_we;
               w_data = r_we ? r_wdata : '0;
               w_next = DONE;
            end
         end
         MERGE_WR: begin
            w_wren = 1'b1;
            w_data = w_merged;
            w_next = DONE;
         end
         DONE: begin
            w_cpu_ack = (r_id == REQ_CPU);
            w_ss_ack  = (r_id == REQ_SS);
            w_next    = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_id        <= REQ_CPU;
         r_we        <= 1'b0;
         r_hw        <= 1'b0;
         r_half      <= 1'b0;
         r_word      <= '0;
         r_wdata     <= '0;
         r_merge     <= '0;
         r_cpu_rdata <= '0;
         r_ss_rdata  <= '0;
      end else begin
         if (r_state == IDLE && w_grant_valid) begin
            r_id <= w_grant_id;
            if (w_grant_id == REQ_CPU) begin
               r_we    <= bus.cpu_we;
               r_hw    <= bus.cpu_hw;
               r_half  <= bus.cpu_addr[0];
               r_word  <= bus.cpu_addr[ADDR_W:1];
               r_wdata <= bus.cpu_wdata;
            end else begin
               r_we    <= bus.ss_we;
               r_hw    <= 1'b0;
               r_half  <= 1'b0;
               r_word  <= bus.ss_addr;
               r_wdata <= bus.ss_wdata;
            end
         end
         if (r_state == ACCESS) begin
            if (r_we && r_hw) begin
               r_merge <= ram_q_a;
            end else if (!r_we && r_id == REQ_SS) begin
               r_ss_rdata <= ram_q_a;
            end else if (!r_we && r_hw) begin
               r_cpu_rdata <= r_half ? {{HALF_W{1'b0}}, ram_q_a[DATA_W-1:HALF_W]}
                                     : {{HALF_W{1'b0}}, ram_q_a[HALF_W-1:0]};
            end else if (!r_we) begin
               r_cpu_rdata <= ram_q_a;
            end
         end
      end
   end

   // Free-running renderer pipeline stage, independent of the port-A FSM.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_render_data <= '0;
      end else begin
         r_render_data <= ram_q_b;
      end
   end

   // Gating with reset keeps an interrupted read-modify-write from landing in RAM.
   assign ram_wren_a    = w_wren & ~reset;
   assign ram_address_a = r_word;
   assign ram_data_a    = w_data;
   assign ram_address_b = render_addr;
   assign ram_wren_b    = 1'b0;
   assign render_data   = r_render_data;
   assign dbg_state     = r_state;
   assign bus.cpu_ack   = w_cpu_ack;
   assign bus.ss_ack    = w_ss_ack;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.ss_rdata  = r_ss_rdata;
endmodule

// File: tb/tb_pal_ram_ctrl.sv
// Self-checking bench for pal_ram_ctrl with a behavioural dual-port RAM and a read-data scoreboard.
module tb_pal_ram_ctrl;
   import pal_ctrl_pkg::*;

   localparam int AW = 14;
   localparam int DW = 32;

   logic          clock;
   logic          reset;
   logic          mem_init;
   logic          ram_wren_a;
   logic [AW-1:0] ram_address_a;
   logic [DW-1:0] ram_data_a;
   logic [DW-1:0] ram_q_a;
   logic [DW-1:0] ram_q_b;
   logic [AW-1:0] render_addr;
   logic [DW-1:0] render_data;
   logic [AW-1:0] ram_address_b;
   logic          ram_wren_b;
   pal_state_e    dbg_state;

   pal_ram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) u_bus ();

   pal_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
      .clock         (clock),
      .reset         (reset),
      .bus           (u_bus),
      .ram_wren_a    (ram_wren_a),
      .ram_address_a (ram_address_a),
      .ram_data_a    (ram_data_a),
      .ram_q_a       (ram_q_a),
      .ram_q_b       (ram_q_b),
      .render_addr   (render_addr),
      .render_data   (render_data),
      .ram_address_b (ram_address_b),
      .ram_wren_b    (ram_wren_b),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock / reset / RAM model ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always @(posedge clock) begin
      if (mem_init) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
      end else if (ram_wren_a) begin
         mem[ram_address_a] <= ram_data_a;
      end
   end

   assign ram_q_a = mem[ram_address_a];
   assign ram_q_b = mem[ram_address_b];

   // ---------------- scoreboard state ----------------
   int errors = 0;
   int checks = 0;
   logic [DW-1:0] cpu_exp_q[$];
   logic [DW-1:0] ss_exp_q[$];
   logic [DW-1:0] model [int];

   int cyc = 0;
   int wren_cnt = 0;
   int cpu_ack_cnt = 0;
   int ss_ack_cnt = 0;
   int overlap_cnt = 0;
   int cpu_ack_t = 0;
   int ss_ack_t = 0;

   always @(negedge clock) begin
      cyc++;
      if (ram_wren_a) wren_cnt++;
      if (u_bus.cpu_ack) begin
         cpu_ack_cnt++;
         cpu_ack_t = cyc;
      end
      if (u_bus.ss_ack) begin
         ss_ack_cnt++;
         ss_ack_t = cyc;
      end
      if (u_bus.cpu_ack && u_bus.ss_ack) overlap_cnt++;
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_rd(input int w);
      return model.exists(w) ? model[w] : '0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cpu_op(input logic we, input logic hw, input logic [AW:0] addr,
                         input logic [DW-1:0] wd, input int exp_lat, input bit solo);
      logic [DW-1:0] cur;
      logic [DW-1:0] exp;
      int n;
      int w0;
      @(posedge clock); #1;
      u_bus.cpu_req   = 1'b1;
      u_bus.cpu_we    = we;
      u_bus.cpu_hw    = hw;
      u_bus.cpu_addr  = addr;
      u_bus.cpu_wdata = wd;
      cur = model_rd(int'(addr[AW:1]));
      if (!we) begin
         if (hw) exp = addr[0] ? {16'h0, cur[31:16]} : {16'h0, cur[15:0]};
         else    exp = cur;
         cpu_exp_q.push_back(exp);
      end else begin
         if (hw && addr[0])  cur[31:16] = wd[15:0];
         else if (hw)        cur[15:0]  = wd[15:0];
         else                cur        = wd;
         model[int'(addr[AW:1])] = cur;
      end
      w0 = wren_cnt;
      n = 0;
      while (n < 20) begin
         @(negedge clock);
         n++;
         if (u_bus.cpu_ack) break;
      end
      if (!u_bus.cpu_ack) begin
         chk("cpu_ack_timeout", 32'(n), 32'(exp_lat + 1));
         if (!we && cpu_exp_q.size() > 0) void'(cpu_exp_q.pop_front());
      end else begin
         if (exp_lat > 0) chk("cpu_latency", 32'(n - 1), 32'(exp_lat));
         if (!we) begin
            if (cpu_exp_q.size() == 0) chk("cpu_sb_empty", 32'd1, 32'd0);
            else chk("cpu_rdata", u_bus.cpu_rdata, cpu_exp_q.pop_front());
         end
      end
      @(posedge clock); #1;
      u_bus.cpu_req = 1'b0;
      if (solo) chk("cpu_wren_pulses", 32'(wren_cnt - w0), we ? 32'd1 : 32'd0);
   endtask

   task automatic ss_op(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int exp_lat, input bit solo);
      int n;
      int w0;
      @(posedge clock); #1;
      u_bus.ss_req   = 1'b1;
      u_bus.ss_we    = we;
      u_bus.ss_addr  = addr;
      u_bus.ss_wdata = wd;
      if (!we) ss_exp_q.push_back(model_rd(int'(addr)));
      else     model[int'(addr)] = wd;
      w0 = wren_cnt;
      n = 0;
      while (n < 20) begin
         @(negedge clock);
         n++;
         if (u_bus.ss_ack) break;
      end
      if (!u_bus.ss_ack) begin
         chk("ss_ack_timeout", 32'(n), 32'(exp_lat + 1));
         if (!we && ss_exp_q.size() > 0) void'(ss_exp_q.pop_front());
      end else begin
         if (exp_lat > 0) chk("ss_latency", 32'(n - 1), 32'(exp_lat));
         if (!we) begin
            if (ss_exp_q.size() == 0) chk("ss_sb_empty", 32'd1, 32'd0);
            else chk("ss_rdata", u_bus.ss_rdata, ss_exp_q.pop_front());
         end
      end
      @(posedge clock); #1;
      u_bus.ss_req = 1'b0;
      if (solo) chk("ss_wren_pulses", 32'(wren_cnt - w0), we ? 32'd1 : 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c0;
      int n;
      logic [AW-1:0] w;
      reset = 1'b1;
      mem_init = 1'b1;
      render_addr = '0;
      u_bus.cpu_req = 1'b0; u_bus.cpu_we = 1'b0; u_bus.cpu_hw = 1'b0;
      u_bus.cpu_addr = '0;  u_bus.cpu_wdata = '0;
      u_bus.ss_req = 1'b0;  u_bus.ss_we = 1'b0;
      u_bus.ss_addr = '0;   u_bus.ss_wdata = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_cpu_ack", 32'(u_bus.cpu_ack), 32'd0);
      chk("rst_ss_ack", 32'(u_bus.ss_ack), 32'd0);
      chk("rst_cpu_rdata", u_bus.cpu_rdata, 32'h0);
      chk("rst_ss_rdata", u_bus.ss_rdata, 32'h0);
      chk("rst_render_data", render_data, 32'h0);
      chk("rst_wren_a", 32'(ram_wren_a), 32'd0);
      chk("rst_address_a", 32'(ram_address_a), 32'd0);
      chk("rst_data_a", ram_data_a, 32'h0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clock); #1;
      mem_init = 1'b0;
      reset = 1'b0;

      // Simultaneous requests straight out of reset: CPU first, then SS, twice.
      fork
         cpu_op(1'b1, 1'b0, 15'h0040, 32'hA5A5_0001, 2, 1'b0);
         ss_op(1'b1, 14'h0021, 32'h5A5A_0002, 5, 1'b0);
      join
      chk("tie1_cpu_first", 32'(cpu_ack_t < ss_ack_t), 32'd1);
      fork
         cpu_op(1'b0, 1'b0, 15'h0040, 32'h0, 2, 1'b0);
         ss_op(1'b0, 14'h0021, 32'h0, 5, 1'b0);
      join
      chk("tie2_cpu_first", 32'(cpu_ack_t < ss_ack_t), 32'd1);

      // Word write then read.
      cpu_op(1'b1, 1'b0, 15'h0010, 32'hDEAD_BEEF, 2, 1'b1);
      cpu_op(1'b0, 1'b0, 15'h0010, 32'h0, 2, 1'b1);

      // Halfword read-modify-write on both halves, plus halfword reads.
      cpu_op(1'b1, 1'b0, 15'h0010, 32'h1234_5678, 2, 1'b1);
      cpu_op(1'b1, 1'b1, 15'h0011, 32'h0000_ABCD, 3, 1'b1);
      cpu_op(1'b0, 1'b0, 15'h0010, 32'h0, 2, 1'b1);
      cpu_op(1'b1, 1'b1, 15'h0010, 32'hFFFF_1111, 3, 1'b1);
      cpu_op(1'b0, 1'b0, 15'h0010, 32'h0, 2, 1'b1);
      cpu_op(1'b0, 1'b1, 15'h0011, 32'h0, 2, 1'b1);
      cpu_op(1'b0, 1'b1, 15'h0010, 32'h0, 2, 1'b1);

      // Savestate word read at the top address; CPU must stay silent.
      ss_op(1'b1, 14'h3FFF, 32'h0000_FFFF, 2, 1'b1);
      c0 = cpu_ack_cnt;
      ss_op(1'b0, 14'h3FFF, 32'h0, 2, 1'b1);
      chk("ss_no_cpu_ack", 32'(cpu_ack_cnt - c0), 32'd0);

      // Reset landing in the MERGE_WR cycle of a halfword write.
      c0 = cpu_ack_cnt;
      @(posedge clock); #1;
      u_bus.cpu_req = 1'b1; u_bus.cpu_we = 1'b1; u_bus.cpu_hw = 1'b1;
      u_bus.cpu_addr = 15'h0011; u_bus.cpu_wdata = 32'h0000_5555;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      chk("rmw_rst_wren", 32'(ram_wren_a), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      u_bus.cpu_req = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      chk("rmw_rst_no_ack", 32'(cpu_ack_cnt - c0), 32'd0);
      chk("rmw_rst_state", 32'(dbg_state), 32'(IDLE));
      chk("rmw_rst_ram", mem[8], model_rd(8));
      cpu_op(1'b0, 1'b0, 15'h0010, 32'h0, 2, 1'b1);

      // Renderer collision on word 5.
      render_addr = 14'd5;
      fork
         cpu_op(1'b1, 1'b0, 15'h000A, 32'h0000_7FFF, 2, 1'b1);
         begin
            n = 0;
            while (n < 20) begin
               @(negedge clock);
               n++;
               if (ram_wren_a && ram_address_a == 14'd5) break;
            end
            chk("render_wr_seen", 32'(ram_wren_a && ram_address_a == 14'd5), 32'd1);
            @(negedge clock);
            chk("render_old", render_data, 32'h0);
            @(negedge clock);
            chk("render_new", render_data, 32'h0000_7FFF);
         end
      join
      chk("render_addr_b", 32'(ram_address_b), 32'd5);
      chk("render_wren_b", 32'(ram_wren_b), 32'd0);

      // Random CPU traffic over a small window, mixing word and halfword accesses.
      for (int i = 0; i < 12; i++) begin
         logic we;
         logic hw;
         w  = 14'(12'h100 + $urandom_range(0, 3));
         we = 1'($urandom_range(0, 1));
         hw = 1'($urandom_range(0, 1));
         cpu_op(we, hw, {w, 1'($urandom_range(0, 1))}, $urandom(),
                (we && hw) ? 3 : 2, 1'b1);
      end

      chk("cpu_sb_drained", 32'(cpu_exp_q.size()), 32'd0);
      chk("ss_sb_drained", 32'(ss_exp_q.size()), 32'd0);
      chk("ack_overlap", 32'(overlap_cnt), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end
endmodule
